sha256_arbiter: RTL

Shares a single `sha256_processor` between two byte-stream requesters, such as the UART front end and a second on-chip client. Each requester streams a message with a valid/ready handshake. The arbiter grants whole messages round-robin, holds the grant until the digest returns, and routes the digest (or a timeout error) back to the granted requester. It sits between the requester front ends and the processor's `start`/`data_*`/`hash_out`/`done` port.

---
 rtl/sha256_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256_processor between two byte-stream requesters.
// Whole messages are granted; the grant is held until the digest or a timeout error is returned.
module sha256_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid_i,
  input  logic [7:0]   req0_data_i,
  input  logic         req0_last_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [7:0]   req1_data_i,
  input  logic         req1_last_i,
  output logic         req1_ready_o,
  output logic         rsp0_valid_o,
  output logic         rsp1_valid_o,
  output logic [255:0] rsp_hash_o,
  output logic         rsp_err_o,
  output logic         proc_start_o,
  output logic         proc_data_valid_o,
  output logic         proc_data_last_o,
  output logic [7:0]   proc_data_in_o,
  input  logic [255:0] proc_hash_out_i,
  input  logic         proc_done_i,
  output logic         busy_o,
  output logic         grant_id_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [7:0]     pdata_q, pdata_d;
  logic           pvalid_q, pvalid_d;
  logic           plast_q, plast_d;
  logic [255:0]   hash_q, hash_d;
  logic           err_q, err_d;

  logic [1:0]      req_valid, req_last, ready, rsp_valid;
  logic [1:0][7:0] req_data;
  logic            hs;

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign req_last  = {req1_last_i, req0_last_i};
  assign req_data  = {req1_data_i, req0_data_i};

  // Per-requester ready/response decode; only the granted requester ever sees either.
  for (genvar g = 0; g < 2; g++) begin : g_req
    assign ready[g]     = (state_q == S_STREAM) && (grant_q == 1'(g));
    assign rsp_valid[g] = (state_q == S_RESP)   && (grant_q == 1'(g));
  end

  assign hs = |(ready & req_valid);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    plast_d  = 1'b0;
    hash_d   = hash_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        // On a tie the requester not granted last wins.
        if (req_valid == 2'b11) begin
          grant_d = ~grant_q;
          state_d = S_STREAM;
        end else if (req_valid[0]) begin
          grant_d = 1'b0;
          state_d = S_STREAM;
        end else if (req_valid[1]) begin
          grant_d = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs) begin
          pdata_d  = req_data[grant_q];
          pvalid_d = 1'b1;
          if (req_last[grant_q]) begin
            plast_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A done arriving on the final timeout cycle still delivers the digest.
        if (proc_done_i) begin
          hash_d  = proc_hash_out_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          hash_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b1;
      cnt_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      plast_q  <= 1'b0;
      hash_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      plast_q  <= plast_d;
      hash_q   <= hash_d;
      err_q    <= err_d;
    end
  end

  assign req0_ready_o      = ready[0];
  assign req1_ready_o      = ready[1];
  assign rsp0_valid_o      = rsp_valid[0];
  assign rsp1_valid_o      = rsp_valid[1];
  assign rsp_hash_o        = hash_q;
  assign rsp_err_o         = err_q;
  assign proc_data_in_o    = pdata_q;
  assign proc_data_valid_o = pvalid_q;
  assign proc_data_last_o  = plast_q;
  assign proc_start_o      = plast_q;
  assign busy_o            = (state_q != S_IDLE);
  assign grant_id_o        = grant_q;

endmodule
